// File: rtl/sram_mem_controller.sv
// Purpose : runs each MEM-stage load/store as two 16-bit half-word SRAM transfers
//           (low half, then high half), each phase lasting WAIT_CYCLES+1 cycles.
// Latency : miss 2*(WAIT_CYCLES+1)+1 cycles from request to ready; buffer hit 1 cycle.
// Backpres: ready=0 while an access is in flight; the pipeline freezes on ~ready.
// Ports   : clk/rst (async, active high); wr_en/rd_en/address/write_data from MEM;
//           read_data/ready to MEM; sram_addr/sram_dq_out/sram_dq_oe/sram_we_n to
//           the pads, sram_dq_in from the pads.
// Option  : `define SRAM_READ_BUFFER_EN adds a one-word read buffer (hit skips SRAM).
module sram_mem_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        op_wr;
  logic [31:0] widx_q;
  logic [31:0] wdata_q;
  logic [31:0] widx_in;
  logic        req;
  logic        phase_last;
  logic        hit;
  logic [31:0] hit_dat;

  // Word index wraps modulo 2^32; the byte offset bits fall out of the shift.
  assign widx_in    = (address - 32'(ADDR_BASE)) >> 2;
  assign req        = rd_en | wr_en;
  assign phase_last = (cnt == 3'(WAIT_CYCLES));

`ifdef SRAM_READ_BUFFER_EN
  logic        buf_vld;
  logic [31:0] buf_widx;
  logic [31:0] buf_dat;

  // A write request takes priority, so only a pure read can hit.
  assign hit     = rd_en & ~wr_en & buf_vld & (buf_widx == widx_in);
  assign hit_dat = buf_dat;

  // Filled on every read completion; kept coherent by writes to the same word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld  <= 1'b0;
      buf_widx <= '0;
      buf_dat  <= '0;
    end else if (state == HIGH && phase_last) begin
      if (!op_wr) begin
        buf_vld  <= 1'b1;
        buf_widx <= widx_q;
        buf_dat  <= {sram_dq_in, read_data[15:0]};
      end else if (buf_vld && buf_widx == widx_q) begin
        buf_dat  <= wdata_q;
      end
    end
  end
`else
  logic unused_widx;

  assign hit         = 1'b0;
  assign hit_dat     = '0;
  // Only the low index bits reach the SRAM when there is no buffer to compare against.
  assign unused_widx = ^widx_q[31:SRAM_AW-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
      sram_addr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (hit) begin
            read_data <= hit_dat;
          end else if (req) begin
            op_wr     <= wr_en;
            widx_q    <= widx_in;
            wdata_q   <= write_data;
            sram_addr <= {widx_in[SRAM_AW-2:0], 1'b0};
          end
        end
        LOW: begin
          if (phase_last) begin
            cnt       <= '0;
            sram_addr <= {widx_q[SRAM_AW-2:0], 1'b1};
            if (!op_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HIGH: begin
          if (phase_last) begin
            cnt <= '0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Strobe/enable are decoded from registered state so reset clears them at once.
  // we_n rises on the last cycle of each phase to give the SRAM data hold time.
  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (hit)      state_nxt = DONE;
        else if (req) state_nxt = LOW;
      end
      LOW: begin
        sram_dq_oe  = op_wr;
        sram_we_n   = ~(op_wr && (cnt < 3'(WAIT_CYCLES)));
        sram_dq_out = op_wr ? wdata_q[15:0] : 16'd0;
        if (phase_last) state_nxt = HIGH;
      end
      HIGH: begin
        sram_dq_oe  = op_wr;
        sram_we_n   = ~(op_wr && (cnt < 3'(WAIT_CYCLES)));
        sram_dq_out = op_wr ? wdata_q[31:16] : 16'd0;
        if (phase_last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: transaction-level model with per-cycle output compare,
// directed literal checks, then randomized reads/writes with mid-access request drops.
module tb_sram_mem_controller;

  localparam int unsigned ADDR_BASE = 1024;
  localparam int          W         = 2;
  localparam int          SRAM_AW   = 18;
  localparam int          L         = 2 * W + 3;   // offset of DONE from the request cycle

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wr_en = 1'b0;
  logic               rd_en = 1'b0;
  logic [31:0]        address = '0;
  logic [31:0]        write_data = '0;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_dq_out;
  logic [15:0]        sram_dq_in;
  logic               sram_dq_oe;
  logic               sram_we_n;

  sram_mem_controller #(.ADDR_BASE(ADDR_BASE), .WAIT_CYCLES(W), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_half(input int i);
    return 16'(i * 40503 + 4660);
  endfunction

  // ---------------- external SRAM model ----------------
  logic [15:0] mem [0:1023];
  bit          mem_inited = 1'b0;
  assign sram_dq_in = mem[sram_addr[9:0]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_half(i);
      mem_inited <= 1'b1;
    end else if (!sram_we_n) begin
      mem[sram_addr[9:0]] <= sram_dq_out;
    end
  end

  // ---------------- transaction-level reference model ----------------
  // m_k counts cycles since the request was accepted: 1..W+1 low half,
  // W+2..2W+2 high half, L = done.
  logic [15:0] exp_half [0:127];
  bit          m_inited = 1'b0;
  bit          m_busy = 1'b0;
  int          m_k = 0;
  bit          m_wr = 1'b0;
  logic [31:0] m_widx = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rd = '0;
`ifdef SRAM_READ_BUFFER_EN
  bit          b_vld = 1'b0;
  logic [31:0] b_widx = '0;
  logic [31:0] b_dat = '0;
`endif

  function automatic logic [31:0] widx_of(input logic [31:0] a);
    return (a - ADDR_BASE) >> 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (!m_inited) begin
        for (int i = 0; i < 128; i++) exp_half[i] <= init_half(i);
        m_inited <= 1'b1;
      end
      m_busy <= 1'b0;
      m_k    <= 0;
      m_rd   <= '0;
`ifdef SRAM_READ_BUFFER_EN
      b_vld  <= 1'b0;
`endif
    end else if (!m_busy) begin
      if (rd_en || wr_en) begin
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_wr    <= wr_en;
        m_widx  <= widx_of(address);
        m_wdata <= write_data;
`ifdef SRAM_READ_BUFFER_EN
        if (!wr_en && b_vld && b_widx == widx_of(address)) begin
          m_k  <= L;
          m_rd <= b_dat;
        end
`endif
      end
    end else if (m_k == L) begin
      m_busy <= 1'b0;
    end else begin
      // A half reaches the SRAM on the first strobed edge of its phase.
      if (m_wr && m_k == 1)     exp_half[{m_widx[5:0], 1'b0}] <= m_wdata[15:0];
      if (m_wr && m_k == W + 2) exp_half[{m_widx[5:0], 1'b1}] <= m_wdata[31:16];
      if (!m_wr && m_k == W + 1) m_rd[15:0] <= exp_half[{m_widx[5:0], 1'b0}];
      if (m_k == 2 * W + 2) begin
        if (!m_wr) m_rd[31:16] <= exp_half[{m_widx[5:0], 1'b1}];
`ifdef SRAM_READ_BUFFER_EN
        if (!m_wr) begin
          b_vld  <= 1'b1;
          b_widx <= m_widx;
          b_dat  <= {exp_half[{m_widx[5:0], 1'b1}], m_rd[15:0]};
        end else if (b_vld && b_widx == m_widx) begin
          b_dat  <= m_wdata;
        end
`endif
      end
      m_k <= m_k + 1;
    end
  end

  logic e_phase, e_half, e_ready, e_oe, e_we;
  int   e_pos;
  always_comb begin
    e_phase = 1'b0; e_half = 1'b0; e_pos = 0;
    e_ready = 1'b0; e_oe = 1'b0; e_we = 1'b1;
    if (!m_busy)            e_ready = !(rd_en || wr_en);
    else if (m_k <= W + 1)  begin e_phase = 1'b1; e_pos = m_k - 1; end
    else if (m_k <= 2*W+2)  begin e_phase = 1'b1; e_half = 1'b1; e_pos = m_k - W - 2; end
    else                    e_ready = 1'b1;
    if (e_phase && m_wr) begin e_oe = 1'b1; e_we = (e_pos == W); end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_oe", 32'(sram_dq_oe), 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
    end else begin
      chk("cyc_ready", 32'(ready), 32'(e_ready));
      chk("cyc_read_data", read_data, m_rd);
      chk("cyc_oe", 32'(sram_dq_oe), 32'(e_oe));
      chk("cyc_we_n", 32'(sram_we_n), 32'(e_we));
      if (e_phase) chk("cyc_addr", 32'(sram_addr), 32'({m_widx[SRAM_AW-2:0], e_half}));
      if (e_oe) chk("cyc_dq_out", 32'(sram_dq_out), 32'(e_half ? m_wdata[31:16] : m_wdata[15:0]));
    end
  end

  // ---------------- stimulus ----------------
  logic               obs_ready [0:31];
  logic [SRAM_AW-1:0] obs_addr  [0:31];
  logic [15:0]        obs_dq    [0:31];
  logic               obs_we_n  [0:31];
  logic [31:0]        obs_rd    [0:31];

  // Called just after a rising edge; request cycle is 0. Returns the first cycle > 0
  // with ready high, or -1 if none within the budget.
  task automatic do_access(input logic w, input logic r, input logic [31:0] a,
                           input logic [31:0] d, input int drop_at, output int done_cyc);
    wr_en = w; rd_en = r; address = a; write_data = d;
    done_cyc = -1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      obs_ready[c] = ready; obs_addr[c] = sram_addr; obs_dq[c] = sram_dq_out;
      obs_we_n[c] = sram_we_n; obs_rd[c] = read_data;
      if (c > 0 && ready && done_cyc < 0) done_cyc = c;
      @(posedge clk); #1;
      if (drop_at > 0 && c + 1 == drop_at) begin
        rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      end
      if (done_cyc >= 0) begin
        rd_en = 1'b0; wr_en = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    rd_en = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int          d;
  int unsigned op;
  int          drop;
  logic [31:0] a;

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("post_rst_read_data", read_data, 32'd0);
    chk("post_rst_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;

    // Write 0xDEADBEEF to 1032 (word 2 -> half-words 4 and 5).
    do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 0, d);
    chk("wr_done_cycle", 32'(d), 32'd7);
    chk("wr_ready_c6", 32'(obs_ready[6]), 32'd0);
    chk("wr_addr_c1", 32'(obs_addr[1]), 32'd4);
    chk("wr_dq_c1", 32'(obs_dq[1]), 32'hBEEF);
    chk("wr_we_c1", 32'(obs_we_n[1]), 32'd0);
    chk("wr_we_c2", 32'(obs_we_n[2]), 32'd0);
    chk("wr_we_c3", 32'(obs_we_n[3]), 32'd1);
    chk("wr_addr_c4", 32'(obs_addr[4]), 32'd5);
    chk("wr_dq_c6", 32'(obs_dq[6]), 32'hDEAD);
    chk("wr_we_c5", 32'(obs_we_n[5]), 32'd0);
    chk("wr_we_c6", 32'(obs_we_n[6]), 32'd1);

    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 0, d);
    chk("rd_done_cycle", 32'(d), 32'd7);
    chk("rd_data", obs_rd[7], 32'hDEADBEEF);

    // Both strobes: the write wins, read_data untouched.
    do_access(1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 0, d);
    chk("both_we_c1", 32'(obs_we_n[1]), 32'd0);
    chk("both_read_data", obs_rd[7], 32'hDEADBEEF);

    // Request dropped at cycle 2 still completes.
    do_access(1'b0, 1'b1, 32'd1038, 32'd0, 2, d);
    chk("drop_done_cycle", 32'(d), 32'd7);
    chk("drop_read_data", obs_rd[7], 32'h0BADF00D);

    do_access(1'b0, 1'b1, 32'd1036, 32'd0, 0, d);
`ifdef SRAM_READ_BUFFER_EN
    chk("hit_done_cycle", 32'(d), 32'd1);
    chk("hit_addr_held", 32'(obs_addr[1]), 32'd7);
    chk("hit_read_data", obs_rd[1], 32'h0BADF00D);
`else
    chk("reread_done_cycle", 32'(d), 32'd7);
    chk("reread_data", obs_rd[7], 32'h0BADF00D);
`endif

    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 0, d);
    do_access(1'b1, 1'b0, 32'd1032, 32'h12345678, 0, d);
    do_access(1'b0, 1'b1, 32'd1032, 32'd0, 0, d);
`ifdef SRAM_READ_BUFFER_EN
    chk("wbuf_done_cycle", 32'(d), 32'd1);
    chk("wbuf_read_data", obs_rd[1], 32'h12345678);
`else
    chk("wr2_done_cycle", 32'(d), 32'd7);
    chk("wr2_read_data", obs_rd[7], 32'h12345678);
`endif

    // Back-to-back reads of 1040 with rd_en held.
    rd_en = 1'b1; address = 32'd1040;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      obs_ready[c] = ready; obs_addr[c] = sram_addr;
      @(posedge clk); #1;
    end
    chk("b2b_ready_c6", 32'(obs_ready[6]), 32'd0);
    chk("b2b_ready_c7", 32'(obs_ready[7]), 32'd1);
    chk("b2b_ready_c8", 32'(obs_ready[8]), 32'd0);
`ifdef SRAM_READ_BUFFER_EN
    chk("b2b_ready_c9", 32'(obs_ready[9]), 32'd1);
    chk("b2b_ready_c10", 32'(obs_ready[10]), 32'd0);
`else
    chk("b2b_addr_c9", 32'(obs_addr[9]), 32'd8);
    chk("b2b_ready_c14", 32'(obs_ready[14]), 32'd0);
    chk("b2b_ready_c15", 32'(obs_ready[15]), 32'd1);
`endif
    wait_idle();

    // Reset in the middle of the high half of a write.
    wr_en = 1'b1; address = 32'd1044; write_data = 32'hCAFEF00D;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst_read_data", read_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;

    // Randomized traffic over a small word window so the buffer sees reuse.
    for (int n = 0; n < 120; n++) begin
      op   = $urandom_range(0, 3);
      a    = ADDR_BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      do_access(op >= 2, op != 2, a, $urandom, drop, d);
      chk("rand_done_seen", 32'(d >= 0), 32'd1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
